// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: RGB565 in, luma conversion, two line
// buffers, |Gx|+|Gy| magnitude, RGB565 out. Four-stage pipeline with a
// single global enable driven by output backpressure.
module sobel_stream_filter #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned LUMA_W = 8,
    parameter int unsigned XW     = $clog2(IMG_W),
    parameter int unsigned YW     = $clog2(IMG_H)
) (
    input  logic              clk_w,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_data,
    output logic              m_sof,
    output logic              m_eol,
    input  logic [1:0]        cfg_mode,
    input  logic [LUMA_W-1:0] cfg_thresh,
    output logic              frame_done,
    output logic              short_frame
);

    // Gradient width: four LUMA_W terms (weights 1,2,1) plus sign
    localparam int unsigned GW = LUMA_W + 3;

    logic en;
    logic acc;

    // Position / mode state
    logic [XW-1:0]     x_q, x_d, pos_x;
    logic [YW-1:0]     y_q, y_d, pos_y;
    logic [1:0]        mode_q, mode_d;
    logic [LUMA_W-1:0] thr_q, thr_d;
    logic              short_d;

    // Luma conversion
    logic [7:0]        r8, g8, b8;
    logic [15:0]       luma16;
    logic [LUMA_W-1:0] y_in;

    // Line buffers (row y-1 in A, row y-2 in B)
    logic [LUMA_W-1:0] lb_a [IMG_W];
    logic [LUMA_W-1:0] lb_b [IMG_W];

    // Stage 1
    logic              v1_q;
    logic [LUMA_W-1:0] lum1_q, a1_q, b1_q;
    logic [XW-1:0]     x1_q;
    logic [YW-1:0]     y1_q;
    logic [1:0]        mode1_q;
    logic [LUMA_W-1:0] thr1_q;

    // Stage 2
    logic              v2_q;
    logic [LUMA_W-1:0] win_q [3][3];
    logic [XW-1:0]     x2_q;
    logic [YW-1:0]     y2_q;
    logic [1:0]        mode2_q;
    logic [LUMA_W-1:0] thr2_q;

    // Stage 3
    logic [GW-1:0]     gx_r, gx_l, gy_b, gy_t;
    logic [GW-1:0]     gx_d, gy_d;
    logic [LUMA_W-1:0] c_d;
    logic              border;
    logic              v3_q;
    logic [GW-1:0]     gx3_q, gy3_q;
    logic [LUMA_W-1:0] c3_q;
    logic              sof3_q, eol3_q, last3_q;
    logic [1:0]        mode3_q;
    logic [LUMA_W-1:0] thr3_q;

    // Stage 4
    logic [GW-1:0]     ax, ay, mag_sum;
    logic [7:0]        mag8, l8;
    logic [15:0]       m_data_d;
    logic              m_valid_q, m_sof_q, m_eol_q, m_last_q;
    logic [15:0]       m_data_q;
    logic              frame_done_q, short_frame_q;

    assign en      = !m_valid_q || m_ready;
    assign acc     = s_valid && en;
    assign s_ready = en;

    // RGB565 -> 8-bit luma with bit-replicated expansion
    always_comb begin
        r8     = {s_data[15:11], s_data[15:13]};
        g8     = {s_data[10:5],  s_data[10:9]};
        b8     = {s_data[4:0],   s_data[4:2]};
        luma16 = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;
        y_in   = LUMA_W'(luma16 >> 8);
    end

    // Next position, frame-start handling and mode latch
    always_comb begin
        pos_x   = s_sof ? '0 : x_q;
        pos_y   = s_sof ? '0 : y_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        short_d = 1'b0;
        if (acc) begin
            if (pos_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (pos_y == YW'(IMG_H - 1)) ? '0 : pos_y + YW'(1);
            end else begin
                x_d = pos_x + XW'(1);
                y_d = pos_y;
            end
            if (s_sof) begin
                mode_d  = cfg_mode;
                thr_d   = cfg_thresh;
                short_d = (x_q != '0) || (y_q != '0);
            end
        end
    end

    // Position counters and latched configuration
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            mode_q        <= '0;
            thr_q         <= '0;
            short_frame_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            mode_q        <= mode_d;
            thr_q         <= thr_d;
            short_frame_q <= short_d;
        end
    end

    // Line buffer shift: A takes the new luma, B takes A's old content
    always_ff @(posedge clk_w) begin
        if (acc) begin
            lb_b[pos_x] <= lb_a[pos_x];
            lb_a[pos_x] <= y_in;
        end
    end

    // Stage 1: luma and line buffer read (read-before-write)
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            lum1_q  <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            mode1_q <= '0;
            thr1_q  <= '0;
        end else if (en) begin
            v1_q <= acc;
            if (acc) begin
                lum1_q  <= y_in;
                a1_q    <= lb_a[pos_x];
                b1_q    <= lb_b[pos_x];
                x1_q    <= pos_x;
                y1_q    <= pos_y;
                mode1_q <= mode_d;
                thr1_q  <= thr_d;
            end
        end
    end

    // Stage 2: 3x3 window, shifted one column per valid pixel
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            x2_q    <= '0;
            y2_q    <= '0;
            mode2_q <= '0;
            thr2_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= b1_q;
                win_q[1][2] <= a1_q;
                win_q[2][2] <= lum1_q;
                x2_q        <= x1_q;
                y2_q        <= y1_q;
                mode2_q     <= mode1_q;
                thr2_q      <= thr1_q;
            end
        end
    end

    // Sobel gradients (two's complement in GW bits) with border masking
    always_comb begin
        gx_r   = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
        gx_l   = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
        gy_b   = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
        gy_t   = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
        border = (x2_q < XW'(2)) || (y2_q < YW'(2));
        gx_d   = border ? '0 : gx_r - gx_l;
        gy_d   = border ? '0 : gy_b - gy_t;
        c_d    = border ? '0 : win_q[1][1];
    end

    // Stage 3: gradient register and position tags
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            gx3_q   <= '0;
            gy3_q   <= '0;
            c3_q    <= '0;
            sof3_q  <= 1'b0;
            eol3_q  <= 1'b0;
            last3_q <= 1'b0;
            mode3_q <= '0;
            thr3_q  <= '0;
        end else if (en) begin
            v3_q <= v2_q;
            if (v2_q) begin
                gx3_q   <= gx_d;
                gy3_q   <= gy_d;
                c3_q    <= c_d;
                sof3_q  <= (x2_q == '0) && (y2_q == '0);
                eol3_q  <= (x2_q == XW'(IMG_W - 1));
                last3_q <= (x2_q == XW'(IMG_W - 1)) && (y2_q == YW'(IMG_H - 1));
                mode3_q <= mode2_q;
                thr3_q  <= thr2_q;
            end
        end
    end

    // Magnitude, saturation, mode select and RGB565 packing
    always_comb begin
        ax      = gx3_q[GW-1] ? GW'(~gx3_q + GW'(1)) : gx3_q;
        ay      = gy3_q[GW-1] ? GW'(~gy3_q + GW'(1)) : gy3_q;
        mag_sum = ax + ay;
        mag8    = (mag_sum > GW'(255)) ? 8'hFF : mag_sum[7:0];
        case (mode3_q)
            2'd1:    l8 = (GW'(mag8) >= GW'(thr3_q)) ? 8'hFF : 8'h00;
            2'd2:    l8 = 8'(c3_q);
            default: l8 = mag8;
        endcase
        m_data_d = {l8[7:3], l8[7:2], l8[7:3]};
    end

    // Stage 4: output register, held while downstream stalls
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= m_valid_q && m_ready && m_last_q;
            if (en) begin
                m_valid_q <= v3_q;
                if (v3_q) begin
                    m_data_q <= m_data_d;
                    m_sof_q  <= sof3_q;
                    m_eol_q  <= eol3_q;
                    m_last_q <= last3_q;
                end
            end
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_sof       = m_sof_q;
    assign m_eol       = m_eol_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;

endmodule
